shift_l_rr_arb: RTL and testbench

- Round-robin arbiter and sequencer sharing one shift_l_nbit left-shift datapath among NUM_REQ requesters.
- Each requester presents an operand/shift-amount pair with a valid/ready handshake.
- The block grants one requester per cycle and drives the shared shifter. It captures the result in a single-entry registered output slot, tagged with the requester ID.
- Sits between PIM issue logic and a shared shift unit, so several lanes can use one shifter instead of one each.

---
 rtl/shift_l_rr_arb.sv | 126 ++++++++++++
 tb/tb_shift_l_rr_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_l_rr_arb.sv
// Round-robin arbiter that shares one left shifter among NUM_REQ requesters. The result lands
// in a one-entry slot one cycle after the grant. req_ready is held low while the full slot is stalled.

module shift_l_nbit #(
   parameter int WIDTH       = 16,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic [WIDTH-1:0]       a_i,
   input  logic [SHIFT_WIDTH-1:0] b_i,
   output logic [WIDTH-1:0]       y_o
);
   assign y_o = a_i << b_i;
endmodule

module shift_l_rr_arb #(
   parameter int WIDTH       = 16,
   parameter int SHIFT_WIDTH = 4,
   parameter int NUM_REQ     = 4,
   localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]       req_a,
   input  logic [NUM_REQ*SHIFT_WIDTH-1:0] req_b,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [WIDTH-1:0]               rsp_y,
   output logic [ID_WIDTH-1:0]            rsp_id
);

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   slot_e                state_q, state_d;
   logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic [ID_WIDTH-1:0]  id_q, id_d;

   logic                 accept;
   logic                 grant_vld;
   logic [ID_WIDTH-1:0]  grant_id;
   logic                 fire;
   logic [WIDTH-1:0]     a_sel;
   logic [SHIFT_WIDTH-1:0] b_sel;
   logic [WIDTH-1:0]     shift_y;

   // A drain and a refill can happen in the same cycle, so a full slot still accepts when rsp_ready is high.
   assign accept = (state_q == SLOT_EMPTY) || rsp_ready;

   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_vld && req_valid[ID_WIDTH'(idx)]) begin
            grant_vld = 1'b1;
            grant_id  = ID_WIDTH'(idx);
         end
      end
   end

   assign fire = accept && grant_vld;

   always_comb begin
      req_ready = '0;
      a_sel     = '0;
      b_sel     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_WIDTH'(i)) begin
            a_sel        = req_a[i*WIDTH +: WIDTH];
            b_sel        = req_b[i*SHIFT_WIDTH +: SHIFT_WIDTH];
            req_ready[i] = fire;
         end
      end
   end

   shift_l_nbit #(
      .WIDTH       (WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_shift (
      .a_i (a_sel),
      .b_i (b_sel),
      .y_o (shift_y)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      y_d     = y_q;
      id_d    = id_q;
      if (fire) begin
         state_d = SLOT_FULL;
         y_d     = shift_y;
         id_d    = grant_id;
         ptr_d   = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end else if (state_q == SLOT_FULL && rsp_ready) begin
         state_d = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         ptr_q   <= '0;
         y_q     <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         y_q     <= y_d;
         id_q    <= id_d;
      end
   end

   assign rsp_valid = (state_q == SLOT_FULL);
   assign rsp_y     = y_q;
   assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_l_rr_arb.sv
// Directed bench for shift_l_rr_arb: stimulus pushes expected results into a queue.
// A separate negedge monitor pops and compares each consumed response.

module tb_shift_l_rr_arb;
   localparam int WIDTH = 16;
   localparam int SW    = 4;
   localparam int NR    = 4;
   localparam int IDW   = 2;

   logic                 clk;
   logic                 rst_n;
   logic [NR-1:0]        req_valid;
   logic [NR-1:0]        req_ready;
   logic [NR*WIDTH-1:0]  req_a;
   logic [NR*SW-1:0]     req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [WIDTH-1:0]     rsp_y;
   logic [IDW-1:0]       rsp_id;

   int n_cmp;
   int n_bad;

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic [IDW-1:0]   id;
   } exp_t;
   exp_t sb_q[$];

   shift_l_rr_arb #(.WIDTH(WIDTH), .SHIFT_WIDTH(SW), .NUM_REQ(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [SW-1:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*SW +: SW]       = b;
   endtask

   task automatic push(input logic [WIDTH-1:0] y, input logic [IDW-1:0] id);
      exp_t e;
      e.y  = y;
      e.id = id;
      sb_q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: a response is consumed on the edge following a negedge where valid and ready are both high.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got y=0x%0h id=%0d with empty scoreboard", rsp_y, rsp_id);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_y", 32'(rsp_y), 32'(e.y));
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
         end
      end
   end

   initial begin
      logic [NR-1:0] fair_oh [5];
      logic [WIDTH-1:0] fair_y [5];
      logic [IDW-1:0] fair_id [5];
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      #22;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_y", 32'(rsp_y), 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single request on requester 2
      set_req(2, 16'h00F3, 4'd4);
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      chk("single_req_ready", 32'(req_ready), 32'h4);
      push(16'h0F30, 2'd2);
      tick();
      req_valid = '0;
      chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
      // Drain without refill: slot empties, data holds
      chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("drain_rsp_y_hold", 32'(rsp_y), 32'h0F30);
      chk("drain_rsp_id_hold", 32'(rsp_id), 32'd2);

      // Fairness with all valid; pointer was left at 3 by the single request
      set_req(0, 16'h1111, 4'd1);
      set_req(1, 16'h2222, 4'd1);
      set_req(2, 16'h0303, 4'd1);
      set_req(3, 16'h4004, 4'd1);
      fair_oh = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      fair_y  = '{16'h8008, 16'h2222, 16'h4444, 16'h0606, 16'h8008};
      fair_id = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("fair_req_ready", 32'(req_ready), 32'(fair_oh[k]));
         push(fair_y[k], fair_id[k]);
         tick();
      end

      // Boundary A=FFFF,B=15 on requester 1 (ptr=0) overwrites the slot while it drains
      req_valid = 4'b0010;
      set_req(1, 16'hFFFF, 4'd15);
      #1;
      chk("bp_setup_req_ready", 32'(req_ready), 32'h2);
      push(16'h8000, 2'd1);
      tick();
      rsp_ready = 1'b0;
      set_req(0, 16'hA5A5, 4'd0);
      set_req(2, 16'h0001, 4'd8);
      set_req(3, 16'h1234, 4'd3);
      req_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_y", 32'(rsp_y), 32'h8000);
         chk("bp_rsp_id", 32'(rsp_id), 32'd1);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_req_ready", 32'(req_ready), 32'h4);
      push(16'h0100, 2'd2);
      tick();
      req_valid = 4'b1001;
      #1;
      chk("after_bp_req_ready", 32'(req_ready), 32'h8);
      push(16'h91A0, 2'd3);
      tick();
      req_valid = 4'b0001;
      #1;
      chk("shift0_req_ready", 32'(req_ready), 32'h1);
      push(16'hA5A5, 2'd0);
      tick();

      // Fill slot from requester 1 (ptr -> 2), then stall it and reset asynchronously
      req_valid = 4'b0010;
      set_req(1, 16'h0F0F, 4'd2);
      tick();
      req_valid = '0;
      rsp_ready = 1'b0;
      chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("pre_rst_rsp_y", 32'(rsp_y), 32'h3C3C);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst_rsp_y", 32'(rsp_y), 32'd0);
      set_req(0, 16'h00FF, 4'd4);
      set_req(3, 16'h0003, 4'd1);
      req_valid = 4'b1001;
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_req_ready", 32'(req_ready), 32'h1);
      push(16'h0FF0, 2'd0);
      tick();
      req_valid = 4'b1000;
      #1;
      chk("post_rst_second_req_ready", 32'(req_ready), 32'h8);
      push(16'h0006, 2'd3);
      tick();
      req_valid = '0;
      tick();
      chk("final_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("final_rsp_y_hold", 32'(rsp_y), 32'h0006);
      tick();
      tick();
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
